// File: rtl/lpc_io_target.sv
// ---------------------------------------------------------------------------
// lpc_io_target
//
// LPC I/O-cycle target. Decodes host I/O read/write cycles on LAD/LFRAME_N.
// Cycles that hit a 2^WINDOW_BITS byte window at BASE_ADDR become
// single-clock register strobes toward the FPGA register bank. The block
// returns SYNC, read data and turn-around nibbles to the host.
//
// Optional feature macro: LPC_SYNC_WAIT_EN
//   defined   : WAIT_CYCLES clocks of SYNC=4'h5 (short wait) precede SYNC=4'h0
//               on both reads and writes; read data is re-latched on the last
//               wait clock.
//   undefined : SYNC is a single 4'h0 clock, no wait-state logic.
//
// Ports:
//   PciReset  in   async active-low reset
//   LpcClock  in   33 MHz LPC clock
//   LFRAME_N  in   LPC frame, active-low
//   LAD_in    in   [3:0] sampled LAD pins
//   LAD_out   out  [3:0] LAD drive value
//   LAD_oe    out  LAD output enable (1 = drive)
//   Addr      out  [7:0] register offset within the window
//   Wr        out  one-clock register write strobe
//   Rd        out  one-clock register read strobe
//   DataWr    out  [7:0] write data, valid while Wr=1
//   DataRd    in   [7:0] read data for Addr, valid by the clock after Rd
// ---------------------------------------------------------------------------
module lpc_io_target #(
    parameter logic [15:0] BASE_ADDR   = 16'h0800,
    parameter int          WINDOW_BITS = 5
) (
    input  logic       PciReset,
    input  logic       LpcClock,
    input  logic       LFRAME_N,
    input  logic [3:0] LAD_in,
    output logic [3:0] LAD_out,
    output logic       LAD_oe,
    output logic [7:0] Addr,
    output logic       Wr,
    output logic       Rd,
    output logic [7:0] DataWr,
    input  logic [7:0] DataRd
);

`ifdef LPC_SYNC_WAIT_EN
    localparam int WAIT_CYCLES = 2;
`endif

    typedef enum logic [3:0] {
        IDLE,
        CYCTYPE,
        ADDR,
        WDATA,
        HTAR,
`ifdef LPC_SYNC_WAIT_EN
        SWAIT,
`endif
        SYNC,
        RDATA,
        PTAR
    } state_t;

    state_t      state, stateNext;
    logic [2:0]  cnt, cntNext;
    logic        isWrite, isWriteNext;
    logic [11:0] addrShift, addrShiftNext;   // first three address nibbles
    logic [3:0]  dataLo, dataLoNext;
    logic [7:0]  rdLatch;

    logic [3:0]  ladOutNext;
    logic        ladOeNext;
    logic        wrNext, rdNext;
    logic        loadAddr, loadDataWr, latchRd;

    logic [15:0] fullAddr;
    logic        hit;

    // Full address is complete while the last nibble sits on LAD_in.
    assign fullAddr = {addrShift, LAD_in};
    assign hit      = (fullAddr[15:WINDOW_BITS] == BASE_ADDR[15:WINDOW_BITS]);

    // Outputs are registered from next-state values, so LAD drive appears in
    // the very clock of the state that owns it.
    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        isWriteNext   = isWrite;
        addrShiftNext = addrShift;
        dataLoNext    = dataLo;
        ladOutNext    = 4'hF;
        ladOeNext     = 1'b0;
        wrNext        = 1'b0;
        rdNext        = 1'b0;
        loadAddr      = 1'b0;
        loadDataWr    = 1'b0;
        latchRd       = 1'b0;

        if (!LFRAME_N) begin
            // START or abort: every low-frame clock re-evaluates, so the last
            // one wins. LAD is released on this edge.
            stateNext = (LAD_in == 4'h0) ? CYCTYPE : IDLE;
            cntNext   = 3'd0;
        end else begin
            case (state)
                IDLE: ;
                CYCTYPE: begin
                    cntNext = 3'd0;
                    if (LAD_in[3:2] == 2'b00) begin
                        isWriteNext = LAD_in[1];
                        stateNext   = ADDR;
                    end else begin
                        stateNext   = IDLE;
                    end
                end
                ADDR: begin
                    addrShiftNext = {addrShift[7:0], LAD_in};
                    if (cnt == 3'd3) begin
                        cntNext = 3'd0;
                        if (hit) begin
                            loadAddr  = 1'b1;
                            rdNext    = !isWrite;
                            stateNext = isWrite ? WDATA : HTAR;
                        end else begin
                            stateNext = IDLE;
                        end
                    end else begin
                        cntNext = cnt + 3'd1;
                    end
                end
                WDATA: begin
                    if (cnt == 3'd0) begin
                        dataLoNext = LAD_in;
                        cntNext    = 3'd1;
                    end else begin
                        loadDataWr = 1'b1;
                        wrNext     = 1'b1;
                        cntNext    = 3'd0;
                        stateNext  = HTAR;
                    end
                end
                HTAR: begin
                    if (cnt == 3'd0) begin
                        cntNext = 3'd1;
                    end else begin
                        latchRd   = !isWrite;
                        cntNext   = 3'd0;
                        ladOeNext = 1'b1;
`ifdef LPC_SYNC_WAIT_EN
                        ladOutNext = 4'h5;
                        stateNext  = SWAIT;
`else
                        ladOutNext = 4'h0;
                        stateNext  = SYNC;
`endif
                    end
                end
`ifdef LPC_SYNC_WAIT_EN
                SWAIT: begin
                    ladOeNext = 1'b1;
                    if (cnt == 3'(WAIT_CYCLES - 1)) begin
                        // Register bank gets the wait time to settle DataRd.
                        latchRd    = !isWrite;
                        cntNext    = 3'd0;
                        ladOutNext = 4'h0;
                        stateNext  = SYNC;
                    end else begin
                        cntNext    = cnt + 3'd1;
                        ladOutNext = 4'h5;
                    end
                end
`endif
                SYNC: begin
                    ladOeNext = 1'b1;
                    cntNext   = 3'd0;
                    if (isWrite) begin
                        ladOutNext = 4'hF;
                        stateNext  = PTAR;
                    end else begin
                        ladOutNext = rdLatch[3:0];
                        stateNext  = RDATA;
                    end
                end
                RDATA: begin
                    ladOeNext = 1'b1;
                    if (cnt == 3'd0) begin
                        ladOutNext = rdLatch[7:4];
                        cntNext    = 3'd1;
                    end else begin
                        ladOutNext = 4'hF;
                        cntNext    = 3'd0;
                        stateNext  = PTAR;
                    end
                end
                PTAR: begin
                    if (cnt == 3'd0) begin
                        cntNext = 3'd1;          // PTAR1: bus released
                    end else begin
                        cntNext   = 3'd0;
                        stateNext = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            isWrite   <= 1'b0;
            addrShift <= 12'h000;
            dataLo    <= 4'h0;
            rdLatch   <= 8'h00;
            LAD_out   <= 4'hF;
            LAD_oe    <= 1'b0;
            Addr      <= 8'h00;
            Wr        <= 1'b0;
            Rd        <= 1'b0;
            DataWr    <= 8'h00;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            isWrite   <= isWriteNext;
            addrShift <= addrShiftNext;
            dataLo    <= dataLoNext;
            LAD_out   <= ladOutNext;
            LAD_oe    <= ladOeNext;
            Wr        <= wrNext;
            Rd        <= rdNext;
            if (latchRd)    rdLatch <= DataRd;
            if (loadAddr)   Addr    <= fullAddr[7:0] - BASE_ADDR[7:0];
            if (loadDataWr) DataWr  <= {LAD_in, dataLo};
        end
    end

endmodule

// File: tb/tb_lpc_io_target.sv
module tb_lpc_io_target;

    logic       PciReset;
    logic       LpcClock = 1'b0;
    logic       LFRAME_N;
    logic [3:0] LAD_in;
    logic [3:0] LAD_out;
    logic       LAD_oe;
    logic [7:0] Addr;
    logic       Wr;
    logic       Rd;
    logic [7:0] DataWr;
    logic [7:0] DataRd;

    int nChecks = 0;
    int nFails  = 0;

    lpc_io_target dut (
        .PciReset (PciReset),
        .LpcClock (LpcClock),
        .LFRAME_N (LFRAME_N),
        .LAD_in   (LAD_in),
        .LAD_out  (LAD_out),
        .LAD_oe   (LAD_oe),
        .Addr     (Addr),
        .Wr       (Wr),
        .Rd       (Rd),
        .DataWr   (DataWr),
        .DataRd   (DataRd)
    );

    always #15 LpcClock = ~LpcClock;

    // Drive one host clock; outputs are observed 1 ns after the edge.
    task automatic step(input logic f, input logic [3:0] lad);
        @(negedge LpcClock);
        LFRAME_N = f;
        LAD_in   = lad;
        @(posedge LpcClock);
        #1;
    endtask

    // START, cycle type and four address nibbles.
    task automatic hdr(input logic [3:0] cyc, input logic [15:0] a);
        logic [15:0] av;
        av = a;
        step(1'b0, 4'h0);
        step(1'b1, cyc);
        step(1'b1, av[15:12]);
        step(1'b1, av[11:8]);
        step(1'b1, av[7:4]);
        step(1'b1, av[3:0]);
    endtask

    task automatic test_reset;
        nChecks++;
        if ({LAD_oe, LAD_out, Addr, Wr, Rd, DataWr} !== {1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 8'h00}) begin
            nFails++;
            $display("FAIL reset_vals: got oe=%b lad=%h addr=%h wr=%b rd=%b dw=%h, want 0 f 00 0 0 00",
                     LAD_oe, LAD_out, Addr, Wr, Rd, DataWr);
        end
    endtask

    // Ends in the PTAR1 clock so a following START is back-to-back.
    task automatic test_write(input logic [15:0] a, input logic [7:0] d);
        logic [7:0] dv;
        logic [7:0] expAddr;
        dv      = d;
        expAddr = a[7:0] - 8'h00;
        hdr(4'h2, a);
        step(1'b1, dv[3:0]);
        step(1'b1, dv[7:4]);
        nChecks++;
        if ({Wr, Rd, Addr, DataWr, LAD_oe} !== {1'b1, 1'b0, expAddr, dv, 1'b0}) begin
            nFails++;
            $display("FAIL wr_strobe: got wr=%b rd=%b addr=%h dw=%h oe=%b, want 1 0 %h %h 0",
                     Wr, Rd, Addr, DataWr, LAD_oe, expAddr, dv);
        end
        step(1'b1, 4'hF);
        nChecks++;
        if ({Wr, LAD_oe} !== 2'b00) begin
            nFails++;
            $display("FAIL wr_htar1: got wr=%b oe=%b, want 0 0", Wr, LAD_oe);
        end
`ifdef LPC_SYNC_WAIT_EN
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'hF);
            nChecks++;
            if ({LAD_oe, LAD_out} !== {1'b1, 4'h5}) begin
                nFails++;
                $display("FAIL wr_wait%0d: got oe=%b lad=%h, want 1 5", i, LAD_oe, LAD_out);
            end
        end
`endif
        step(1'b1, 4'hF);
        nChecks++;
        if ({LAD_oe, LAD_out} !== {1'b1, 4'h0}) begin
            nFails++;
            $display("FAIL wr_sync: got oe=%b lad=%h, want 1 0", LAD_oe, LAD_out);
        end
        step(1'b1, 4'hF);
        nChecks++;
        if ({LAD_oe, LAD_out} !== {1'b1, 4'hF}) begin
            nFails++;
            $display("FAIL wr_ptar0: got oe=%b lad=%h, want 1 f", LAD_oe, LAD_out);
        end
        step(1'b1, 4'hF);
        nChecks++;
        if ({LAD_oe, Wr} !== 2'b00) begin
            nFails++;
            $display("FAIL wr_ptar1: got oe=%b wr=%b, want 0 0", LAD_oe, Wr);
        end
    endtask

    task automatic test_read(input logic [15:0] a, input logic [7:0] d);
        logic [7:0] dv;
        logic [7:0] expAddr;
        dv      = d;
        expAddr = a[7:0];
        DataRd  = dv;
        hdr(4'h0, a);
        nChecks++;
        if ({Rd, Wr, Addr, LAD_oe} !== {1'b1, 1'b0, expAddr, 1'b0}) begin
            nFails++;
            $display("FAIL rd_strobe: got rd=%b wr=%b addr=%h oe=%b, want 1 0 %h 0",
                     Rd, Wr, Addr, LAD_oe, expAddr);
        end
        step(1'b1, 4'hF);
        nChecks++;
        if ({Rd, LAD_oe} !== 2'b00) begin
            nFails++;
            $display("FAIL rd_htar1: got rd=%b oe=%b, want 0 0", Rd, LAD_oe);
        end
`ifdef LPC_SYNC_WAIT_EN
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'hF);
            nChecks++;
            if ({LAD_oe, LAD_out} !== {1'b1, 4'h5}) begin
                nFails++;
                $display("FAIL rd_wait%0d: got oe=%b lad=%h, want 1 5", i, LAD_oe, LAD_out);
            end
        end
`endif
        step(1'b1, 4'hF);
        nChecks++;
        if ({LAD_oe, LAD_out} !== {1'b1, 4'h0}) begin
            nFails++;
            $display("FAIL rd_sync: got oe=%b lad=%h, want 1 0", LAD_oe, LAD_out);
        end
        step(1'b1, 4'hF);
        nChecks++;
        if ({LAD_oe, LAD_out} !== {1'b1, dv[3:0]}) begin
            nFails++;
            $display("FAIL rd_data0: got oe=%b lad=%h, want 1 %h", LAD_oe, LAD_out, dv[3:0]);
        end
        step(1'b1, 4'hF);
        nChecks++;
        if ({LAD_oe, LAD_out} !== {1'b1, dv[7:4]}) begin
            nFails++;
            $display("FAIL rd_data1: got oe=%b lad=%h, want 1 %h", LAD_oe, LAD_out, dv[7:4]);
        end
        step(1'b1, 4'hF);
        nChecks++;
        if ({LAD_oe, LAD_out} !== {1'b1, 4'hF}) begin
            nFails++;
            $display("FAIL rd_ptar0: got oe=%b lad=%h, want 1 f", LAD_oe, LAD_out);
        end
        step(1'b1, 4'hF);
        nChecks++;
        if ({LAD_oe, Rd} !== 2'b00) begin
            nFails++;
            $display("FAIL rd_ptar1: got oe=%b rd=%b, want 0 0", LAD_oe, Rd);
        end
    endtask

    task automatic test_ignored;
        logic [3:0] tail [8];
        tail = '{4'h5, 4'hA, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        // Miss: 0x0820 is just past the 32-byte window.
        hdr(4'h2, 16'h0820);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tail[i]);
            nChecks++;
            if ({LAD_oe, Wr, Rd} !== 3'b000) begin
                nFails++;
                $display("FAIL miss_quiet%0d: got oe=%b wr=%b rd=%b, want 0 0 0", i, LAD_oe, Wr, Rd);
            end
        end
        // Memory read cycle type; the in-window address that follows is ignored.
        hdr(4'h4, 16'h0809);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tail[i]);
            nChecks++;
            if ({LAD_oe, Wr, Rd} !== 3'b000) begin
                nFails++;
                $display("FAIL mem_quiet%0d: got oe=%b wr=%b rd=%b, want 0 0 0", i, LAD_oe, Wr, Rd);
            end
        end
    endtask

    task automatic test_abort;
        DataRd = 8'h3C;
        hdr(4'h0, 16'h080B);
        step(1'b1, 4'hF);
`ifdef LPC_SYNC_WAIT_EN
        step(1'b1, 4'hF);
        step(1'b1, 4'hF);
`endif
        step(1'b1, 4'hF);
        step(1'b1, 4'hF);
        nChecks++;
        if ({LAD_oe, LAD_out} !== {1'b1, 4'hC}) begin
            nFails++;
            $display("FAIL abort_pre: got oe=%b lad=%h, want 1 c", LAD_oe, LAD_out);
        end
        step(1'b0, 4'hF);
        nChecks++;
        if ({LAD_oe, Rd, Wr} !== 3'b000) begin
            nFails++;
            $display("FAIL abort_edge: got oe=%b rd=%b wr=%b, want 0 0 0", LAD_oe, Rd, Wr);
        end
        // Two low-frame START clocks in a row; the later one starts the cycle.
        step(1'b0, 4'h0);
        test_write(16'h0801, 8'h55);
    endtask

    task automatic test_back_to_back;
        test_write(16'h081F, 8'h77);
        test_read(16'h0810, 8'hE4);
    endtask

    task automatic test_reset_mid;
        hdr(4'h2, 16'h0805);
        step(1'b1, 4'h3);
        step(1'b1, 4'hC);
        step(1'b1, 4'hF);
`ifdef LPC_SYNC_WAIT_EN
        step(1'b1, 4'hF);
        step(1'b1, 4'hF);
`endif
        step(1'b1, 4'hF);
        nChecks++;
        if ({LAD_oe, LAD_out, DataWr} !== {1'b1, 4'h0, 8'hC3}) begin
            nFails++;
            $display("FAIL rst_pre_sync: got oe=%b lad=%h dw=%h, want 1 0 c3", LAD_oe, LAD_out, DataWr);
        end
        #3;
        PciReset = 1'b0;
        #1;
        nChecks++;
        if ({LAD_oe, LAD_out, Addr, Wr, Rd, DataWr} !== {1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 8'h00}) begin
            nFails++;
            $display("FAIL rst_async: got oe=%b lad=%h addr=%h wr=%b rd=%b dw=%h, want 0 f 00 0 0 00",
                     LAD_oe, LAD_out, Addr, Wr, Rd, DataWr);
        end
        step(1'b1, 4'hF);
        @(negedge LpcClock);
        PciReset = 1'b1;
        test_read(16'h0800, 8'h5A);
    endtask

`ifdef LPC_SYNC_WAIT_EN
    // Data presented only during the wait window must still be returned.
    task automatic test_sync_wait;
        DataRd = 8'h00;
        hdr(4'h0, 16'h0804);
        nChecks++;
        if ({Rd, Addr} !== {1'b1, 8'h04}) begin
            nFails++;
            $display("FAIL sw_strobe: got rd=%b addr=%h, want 1 04", Rd, Addr);
        end
        step(1'b1, 4'hF);
        step(1'b1, 4'hF);
        DataRd = 8'h1B;
        nChecks++;
        if ({LAD_oe, LAD_out} !== {1'b1, 4'h5}) begin
            nFails++;
            $display("FAIL sw_wait0: got oe=%b lad=%h, want 1 5", LAD_oe, LAD_out);
        end
        step(1'b1, 4'hF);
        nChecks++;
        if ({LAD_oe, LAD_out} !== {1'b1, 4'h5}) begin
            nFails++;
            $display("FAIL sw_wait1: got oe=%b lad=%h, want 1 5", LAD_oe, LAD_out);
        end
        step(1'b1, 4'hF);
        nChecks++;
        if ({LAD_oe, LAD_out} !== {1'b1, 4'h0}) begin
            nFails++;
            $display("FAIL sw_sync: got oe=%b lad=%h, want 1 0", LAD_oe, LAD_out);
        end
        step(1'b1, 4'hF);
        nChecks++;
        if (LAD_out !== 4'hB) begin
            nFails++;
            $display("FAIL sw_data0: got %h want b", LAD_out);
        end
        step(1'b1, 4'hF);
        nChecks++;
        if (LAD_out !== 4'h1) begin
            nFails++;
            $display("FAIL sw_data1: got %h want 1", LAD_out);
        end
        step(1'b1, 4'hF);
        step(1'b1, 4'hF);
        nChecks++;
        if (LAD_oe !== 1'b0) begin
            nFails++;
            $display("FAIL sw_ptar1: got oe=%b want 0", LAD_oe);
        end
    endtask
`endif

    initial begin
        PciReset = 1'b0;
        LFRAME_N = 1'b1;
        LAD_in   = 4'hF;
        DataRd   = 8'h00;
        repeat (2) @(posedge LpcClock);
        #1;
        test_reset;
        @(negedge LpcClock);
        PciReset = 1'b1;
        step(1'b1, 4'hF);
        test_write(16'h0809, 8'hA5);
        step(1'b1, 4'hF);
        test_read(16'h080B, 8'h3C);
        step(1'b1, 4'hF);
        test_ignored;
        test_abort;
        test_back_to_back;
        test_reset_mid;
`ifdef LPC_SYNC_WAIT_EN
        test_sync_wait;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
